// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared state encoding, defaults and helpers for cpu_run_ctrl
package cpu_run_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_HOLD = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_HALTED   = 3'd3;
    localparam logic [2:0] ST_TMO      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_RST_HOLD = ST_RST_HOLD,
        S_RUN      = ST_RUN,
        S_HALTED   = ST_HALTED,
        S_TMO      = ST_TMO
    } run_state_t;

    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_PC_W        = 32;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_STALL_LIMIT = 16;
    localparam int DEF_TIMEOUT     = 100000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - run-control signal bundle between controller and core/bench
interface cpu_run_ctrl_if
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic             abort;
    logic             pc_valid;
    logic [PC_W-1:0]  pc;
    logic             retire;
    logic             core_reset;
    logic             running;
    logic             done;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output start, abort, pc_valid, pc, retire,
        input  core_reset, running, done, timed_out, cycle_count, retire_count
    );

    modport slave (
        input  start, abort, pc_valid, pc, retire,
        output core_reset, running, done, timed_out, cycle_count, retire_count
    );

endinterface

// File: rtl/cpu_run_ctrl_pc_stall_detect.sv
// rtl/cpu_run_ctrl_pc_stall_detect.sv - detects the core parking in a PC self-loop
module pc_stall_detect
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_en,
    input  logic            i_pc_valid,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_halt_hit
);

    localparam int              SC_W    = clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STALL_LIMIT);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STALL_LIMIT - 1);

    logic [PC_W-1:0] r_last_pc;
    logic            r_last_valid;
    logic [SC_W-1:0] r_stall_cnt;
    logic            w_repeat;

    // The first valid PC after a clear only primes r_last_pc; it is never a repeat.
    assign w_repeat   = i_en & i_pc_valid & r_last_valid & (i_pc == r_last_pc);
    assign o_halt_hit = w_repeat & (r_stall_cnt == SC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_pc    <= '0;
            r_last_valid <= 1'b0;
            r_stall_cnt  <= '0;
        end else if (i_clear) begin
            r_last_pc    <= '0;
            r_last_valid <= 1'b0;
            r_stall_cnt  <= '0;
        end else if (i_en && i_pc_valid) begin
            if (w_repeat) begin
                if (r_stall_cnt != SC_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_last_pc    <= i_pc;
                r_last_valid <= 1'b1;
                r_stall_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - core reset sequencer, cycle/retire counters and end-of-run detection
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int PC_W        = DEF_PC_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    cpu_run_ctrl_if.slave bus
);

    localparam int               HOLD_W    = clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    run_state_t        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_core_reset;
    logic              r_running;
    logic              r_done;
    logic              r_timed_out;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_retire_count;
    logic              w_halt_hit;
    logic              w_stall_clear;
    logic              w_stall_en;

    // Holding the detector clear through RST_HOLD guarantees a clean slate on RUN entry.
    assign w_stall_clear = (r_state == S_RST_HOLD);
    assign w_stall_en    = (r_state == S_RUN);

    pc_stall_detect #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_stall_clear),
        .i_en       (w_stall_en),
        .i_pc_valid (bus.pc_valid),
        .i_pc       (bus.pc),
        .o_halt_hit (w_halt_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_hold_cnt     <= '0;
            r_core_reset   <= 1'b1;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_timed_out    <= 1'b0;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else if (bus.abort) begin
            // Abort outranks start; counters and flags stay for readout.
            r_state      <= S_IDLE;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED, S_TMO: begin
                    if (bus.start) begin
                        r_state        <= S_RST_HOLD;
                        r_hold_cnt     <= '0;
                        r_core_reset   <= 1'b1;
                        r_running      <= 1'b0;
                        r_done         <= 1'b0;
                        r_timed_out    <= 1'b0;
                        r_cycle_count  <= '0;
                        r_retire_count <= '0;
                    end
                end
                S_RST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                        r_running    <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // Counters only advance on edges that stay in RUN, so they freeze at exit.
                    if (w_halt_hit) begin
                        r_state   <= S_HALTED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (r_cycle_count == TMO_LAST) begin
                        r_state     <= S_TMO;
                        r_running   <= 1'b0;
                        r_timed_out <= 1'b1;
                    end else begin
                        if (r_cycle_count != CNT_MAX) r_cycle_count <= r_cycle_count + 1'b1;
                        if (bus.retire && (r_retire_count != CNT_MAX))
                            r_retire_count <= r_retire_count + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_core_reset <= 1'b1;
                    r_running    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_reset   = r_core_reset;
    assign bus.running      = r_running;
    assign bus.done         = r_done;
    assign bus.timed_out    = r_timed_out;
    assign bus.cycle_count  = r_cycle_count;
    assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed vector bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus ();

    cpu_run_ctrl #(
        .RST_CYCLES  (4),
        .PC_W        (32),
        .CNT_W       (32),
        .STALL_LIMIT (8),
        .TIMEOUT     (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic        pc_valid;
        logic [31:0] pc;
        logic        retire;
        logic [67:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [67:0] pack(input logic cr, input logic rn, input logic dn,
                                         input logic to, input logic [31:0] cc,
                                         input logic [31:0] rc);
        return {cr, rn, dn, to, cc, rc};
    endfunction

    function automatic logic [67:0] snap();
        return {bus.core_reset, bus.running, bus.done, bus.timed_out,
                bus.cycle_count, bus.retire_count};
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got cr=%b run=%b done=%b tmo=%b cyc=%0d ret=%0d, want cr=%b run=%b done=%b tmo=%b cyc=%0d ret=%0d",
                      name, act[67], act[66], act[65], act[64], act[63:32], act[31:0],
                      exp[67], exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic add_vec(input logic s, input logic a, input logic v, input logic [31:0] p,
                           input logic r, input logic [67:0] e);
        vec_t t;
        t.start = s; t.abort = a; t.pc_valid = v; t.pc = p; t.retire = r; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic s, input logic a, input logic v, input logic [31:0] p,
                         input logic r);
        bus.start = s; bus.abort = a; bus.pc_valid = v; bus.pc = p; bus.retire = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic v, input logic [31:0] p, input logic r);
        drive(1'b0, 1'b0, v, p, r);
        step();
    endtask

    task automatic restart(input string tag);
        int hi;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        hi = int'(bus.core_reset);
        repeat (3) begin
            step();
            hi += int'(bus.core_reset);
        end
        step();
        check_val({tag, "_rst_hi_cycles"}, hi, 4);
        check({tag, "_run_entry"}, snap(), pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Table: start, reset hold, then a run that parks at 0x3010.
        add_vec(1, 0, 0, 32'h0, 0, pack(1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 32'h0, 0, pack(1, 0, 0, 0, 0, 0));
        add_vec(0, 0, 0, 32'h0, 0, pack(0, 1, 0, 0, 0, 0));
        for (int c = 0; c < 12; c++)
            add_vec(0, 0, 1, (c < 4) ? 32'h3000 + 32'(4 * c) : 32'h3010, (c < 3) ? 1'b1 : 1'b0,
                    pack(0, 1, 0, 0, 32'(c + 1), (c < 3) ? 32'(c + 1) : 32'd3));
        add_vec(0, 0, 1, 32'h3010, 0, pack(0, 0, 1, 0, 32'd12, 32'd3));
        add_vec(0, 0, 1, 32'h3010, 1, pack(0, 0, 1, 0, 32'd12, 32'd3));

        #2 reset = 1'b0;
        #1 check("reset_async", snap(), pack(1, 0, 0, 0, 0, 0));
        step();
        step();
        reset = 1'b1;
        step();
        check("idle_after_reset", snap(), pack(1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].pc_valid, vecs[i].pc, vecs[i].retire);
            step();
            check($sformatf("vec%0d", i), snap(), vecs[i].exp);
        end

        // Invalid cycles inside a repeat streak hold it rather than clearing it.
        restart("t3a");
        for (int c = 0; c < 5; c++) run(1'b1, 32'h3000 + 32'(4 * c), 1'b0);
        for (int c = 5; c < 8; c++) run(1'b1, 32'h3010, 1'b0);
        for (int c = 8; c < 13; c++) run(1'b0, 32'hDEAD_BEEF, 1'b0);
        for (int c = 13; c < 17; c++) run(1'b1, 32'h3010, 1'b0);
        check("t3a_not_yet", snap(), pack(0, 1, 0, 0, 32'd17, 32'd0));
        run(1'b1, 32'h3010, 1'b0);
        check("t3a_done_delayed", snap(), pack(0, 0, 1, 0, 32'd17, 32'd0));

        // A changed PC restarts the streak.
        restart("t3b");
        for (int c = 0; c < 6; c++) run(1'b1, 32'h4000, 1'b0);
        for (int c = 6; c < 14; c++) run(1'b1, 32'h4004, 1'b0);
        check("t3b_cleared_streak", snap(), pack(0, 1, 0, 0, 32'd14, 32'd0));
        run(1'b1, 32'h4004, 1'b0);
        check("t3b_done", snap(), pack(0, 0, 1, 0, 32'd14, 32'd0));

        // Timeout with alternating retire; a start mid-RUN must be ignored.
        restart("t4");
        for (int c = 0; c < 63; c++) begin
            drive((c == 10) ? 1'b1 : 1'b0, 1'b0, 1'b1, 32'h5000 + 32'(4 * c),
                  (c % 2 == 0) ? 1'b1 : 1'b0);
            step();
        end
        check("t4_last_run_cycle", snap(), pack(0, 1, 0, 0, 32'd63, 32'd32));
        run(1'b1, 32'h5000 + 32'(4 * 63), 1'b1);
        check("t4_timeout", snap(), pack(0, 0, 0, 1, 32'd63, 32'd32));
        run(1'b1, 32'h5000, 1'b1);
        check("t4_frozen", snap(), pack(0, 0, 0, 1, 32'd63, 32'd32));
        restart("t4r");
        check_val("t4r_tmo_cleared", int'(bus.timed_out), 0);

        // Halt on the same edge as the timeout: halt wins.
        for (int c = 0; c < 55; c++) run(1'b1, 32'h6000 + 32'(4 * c), 1'b0);
        for (int c = 55; c < 63; c++) run(1'b1, 32'h6000 + 32'(4 * 55), 1'b0);
        check("t5_pre_edge", snap(), pack(0, 1, 0, 0, 32'd63, 32'd0));
        run(1'b1, 32'h6000 + 32'(4 * 55), 1'b0);
        check("t5_halt_wins", snap(), pack(0, 0, 1, 0, 32'd63, 32'd0));

        // abort and start together from HALTED: abort wins, readout kept.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        check("t6_abort_beats_start", snap(), pack(1, 0, 1, 0, 32'd63, 32'd0));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("t6_stays_idle", snap(), pack(1, 0, 1, 0, 32'd63, 32'd0));

        // abort at RUN cycle 20.
        restart("t6");
        for (int c = 0; c < 20; c++) run(1'b1, 32'h7000 + 32'(4 * c), 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h7050, 1'b1);
        step();
        check("t6_abort", snap(), pack(1, 0, 0, 0, 32'd20, 32'd20));

        // Asynchronous reset in the middle of RST_HOLD.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        #2 check("t6_async_reset", snap(), pack(1, 0, 0, 0, 0, 0));
        step();
        reset = 1'b1;
        repeat (6) step();
        check("t6_idle_after_reset", snap(), pack(1, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run-control block in front of the pipelined MIPS core, replacing the fixed clock/reset stimulus of the earlier bench.
- Sequences the core's reset and counts cycles and retired instructions.
- Detects program end (PC stuck in a self-loop) or a cycle-budget timeout, and reports status.
- Lets a bench or on-board controller restart the program without reloading.

Parameters:
- RST_CYCLES, 4: core_reset stays asserted this many cycles after start.
- PC_W, 32: PC width.
- CNT_W, 32: cycle and retire counter width.
- STALL_LIMIT, 16: consecutive valid cycles with an unchanged PC that declare a halt.
- TIMEOUT, 100000: maximum RUN cycles before the timeout state.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low block reset.
- start  in  1  single-cycle pulse; starts or restarts a run.
- abort  in  1  single-cycle pulse; forces the core back into reset.
- pc_valid  in  1  pc holds a real fetched PC this cycle; low while the core stalls.
- pc  in  PC_W  core fetch PC.
- retire  in  1  one instruction retired this cycle.
- core_reset  out  1  active-high reset driven to the core's reset input.
- running  out  1  state is RUN.
- done  out  1  run ended by halt detection.
- timed_out  out  1  run ended by timeout.
- cycle_count  out  CNT_W  number of RUN cycles elapsed.
- retire_count  out  CNT_W  number of instructions retired during RUN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, core_reset=1, running=0, done=0, timed_out=0, both counters 0, stall counter 0, last_pc 0. Applies immediately, including in the middle of a run.
- States: IDLE, RST_HOLD, RUN, HALTED, TMO. All outputs are registered.
- IDLE:
  - core_reset=1.
  - start -> RST_HOLD. Clears the counters, done and timed_out, and loads hold_cnt=0.
- RST_HOLD:
  - core_reset=1; hold_cnt increments every cycle.
  - When hold_cnt==RST_CYCLES-1 -> RUN.
  - Result: core_reset is high for exactly RST_CYCLES cycles counted from the cycle after start.
- RUN:
  - core_reset=0, running=1.
  - cycle_count increments every cycle and saturates at all-ones.
  - retire_count increments on retire and also saturates.
  - Stall detector, per cycle:
    - pc_valid=1 and pc==last_pc: stall_cnt increments.
    - pc_valid=1 and pc!=last_pc: stall_cnt=0 and last_pc=pc.
    - pc_valid=0: stall_cnt and last_pc hold.
  - last_pc is invalid at RUN entry, so the first valid pc only loads last_pc.
  - stall_cnt reaches STALL_LIMIT-1 and increments again -> HALTED, done=1.
  - cycle_count==TIMEOUT-1 at a clock edge -> TMO, timed_out=1.
  - Halt and timeout on the same edge: HALTED wins; timed_out stays 0.
- HALTED / TMO:
  - core_reset=0, so the core keeps spinning.
  - Counters freeze; done or timed_out stays high.
- start:
  - From HALTED, TMO or IDLE: restarts (-> RST_HOLD, counters cleared).
  - In RST_HOLD or RUN: ignored.
- abort:
  - In any non-IDLE state -> IDLE, with core_reset=1 on the next cycle.
  - Counters and status flags hold their values for readout.
  - abort and start in the same cycle: abort wins.
- Stall counter width is clog2(STALL_LIMIT+1) and it saturates; it must never wrap.

Decomposition:
- Shared package/header holds:
  - state encoding localparams (IDLE=0, RST_HOLD=1, RUN=2, HALTED=3, TMO=4, 3-bit);
  - a clog2 function;
  - default parameter constants used by the system top.
- One sub-module, pc_stall_detect: holds last_pc and stall_cnt, outputs halt_hit, and takes a clear input driven on RUN entry.
- The counters and the FSM stay in cpu_run_ctrl.

Test Plan (RST_CYCLES=4, STALL_LIMIT=8, TIMEOUT=64):
1. Release reset, start at cycle 3 -> core_reset high through cycle 7, low from cycle 8; running=1 from cycle 8.
2. In RUN, pc steps 0x3000, 0x3004, ... then sticks at 0x3010 with pc_valid=1 -> done=1 exactly 8 cycles after the first repeat; cycle_count frozen.
3. pc_valid dropped for 5 cycles in the middle of a repeat streak -> streak holds (no clear); done delayed by 5 cycles. A changed pc clears the streak.
4. pc always changing, retire every other cycle -> timed_out=1 when cycle_count reaches 63, retire_count=31 or 32 by phase, done=0. Then start -> counters clear, core_reset high for 4 cycles.
5. Halt streak completing on the same edge as cycle_count==63 -> done=1, timed_out=0.
6. abort at RUN cycle 20 -> next cycle IDLE, core_reset=1, cycle_count=20 held. Then reset pulsed low mid-RST_HOLD -> all outputs return to reset values immediately, with no clock edge needed.
